// File: rtl/colors_to_bytes_if.sv
// Bus of colors_to_bytes: pulse-qualified color input on one side,
// backpressured byte output plus stream status on the other.
interface colors_to_bytes_if #(
    parameter int COLOR_LEN = 12,
    parameter int BYTE_LEN  = 8
);
    logic                 inclk;
    logic [COLOR_LEN-1:0] in;
    logic                 in_done;
    logic                 downstream_rdy;
    logic                 rdy;
    logic                 outclk;
    logic [BYTE_LEN-1:0]  out;
    logic                 done;
    logic                 overflow;

    modport master (
        output inclk, in, in_done, downstream_rdy,
        input  rdy, outclk, out, done, overflow
    );

    modport slave (
        input  inclk, in, in_done, downstream_rdy,
        output rdy, outclk, out, done, overflow
    );
endinterface

// File: rtl/colors_to_bytes.sv
// Unpacks 12-bit colors into 8-bit bytes (2 colors -> 3 bytes) through a small
// byte FIFO, flushing a trailing odd color with a pad nibble when the stream ends.
module colors_to_bytes #(
    parameter int         FIFO_DEPTH = 4,
    parameter logic [3:0] PAD_NIBBLE = 4'b0000
) (
    input logic              clk,
    input logic              rst,
    colors_to_bytes_if.slave bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {RUN, FLUSH, DRAIN, DONE} state_t;

    state_t        state_q, state_d;
    logic          phase_q, phase_d;
    logic [3:0]    residue_q, residue_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] wrPtr_q, wrPtr_d;
    logic [PW-1:0] rdPtr_q, rdPtr_d;
    logic          overflow_q, overflow_d;
    logic          outclk_q;
    logic [7:0]    out_q;
    logic [7:0]    mem_q [FIFO_DEPTH];

    logic       rdy;
    logic       accept;
    logic       pop;
    logic [1:0] pushCnt;
    logic [7:0] pushByte0;
    logic [7:0] pushByte1;

    // Room for a worst-case two-byte push is judged on the registered count only.
    assign rdy    = !rst && (state_q == RUN) && (count_q <= CW'(FIFO_DEPTH - 2));
    assign accept = bus.inclk && rdy;
    assign pop    = (count_q != '0) && bus.downstream_rdy;

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        residue_d = residue_q;
        pushCnt   = 2'd0;
        pushByte0 = '0;
        pushByte1 = '0;
        unique case (state_q)
            RUN: begin
                if (accept) begin
                    if (!phase_q) begin
                        pushCnt   = 2'd1;
                        pushByte0 = bus.in[11:4];
                        residue_d = bus.in[3:0];
                        phase_d   = 1'b1;
                    end else begin
                        pushCnt   = 2'd2;
                        pushByte0 = {residue_q, bus.in[11:8]};
                        pushByte1 = bus.in[7:0];
                        phase_d   = 1'b0;
                    end
                end
                if (bus.in_done) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                if (!phase_q) begin
                    state_d = DRAIN;
                end else if (count_q < CW'(FIFO_DEPTH)) begin
                    pushCnt   = 2'd1;
                    pushByte0 = {residue_q, PAD_NIBBLE};
                    phase_d   = 1'b0;
                    state_d   = DRAIN;
                end
            end
            DRAIN: begin
                if (count_q == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                phase_d = 1'b0;
                state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        count_d    = count_q + CW'(pushCnt) - CW'(pop);
        wrPtr_d    = wrPtr_q + PW'(pushCnt);
        rdPtr_d    = rdPtr_q + PW'(pop);
        overflow_d = overflow_q | (bus.inclk & ~rdy);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RUN;
            phase_q    <= 1'b0;
            residue_q  <= '0;
            count_q    <= '0;
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            overflow_q <= 1'b0;
            outclk_q   <= 1'b0;
            out_q      <= '0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            residue_q  <= residue_d;
            count_q    <= count_d;
            wrPtr_q    <= wrPtr_d;
            rdPtr_q    <= rdPtr_d;
            overflow_q <= overflow_d;
            outclk_q   <= pop;
            if (pop) begin
                out_q <= mem_q[rdPtr_q];
            end
        end
    end

    // Storage needs no reset: pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (pushCnt != 2'd0) begin
            mem_q[wrPtr_q] <= pushByte0;
        end
        if (pushCnt == 2'd2) begin
            mem_q[wrPtr_q + PW'(1)] <= pushByte1;
        end
    end

    assign bus.rdy      = rdy;
    assign bus.outclk   = outclk_q;
    assign bus.out      = out_q;
    assign bus.done     = (state_q == DONE);
    assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_colors_to_bytes.sv
// Self-checking bench for colors_to_bytes: cycle-exact vector table, hand-written
// corner sequences, and random streams checked against a nibble-level model.
module tb_colors_to_bytes;
    localparam int         DEPTH = 4;
    localparam logic [3:0] PAD   = 4'h0;
    localparam int         NV    = 17;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    colors_to_bytes_if bus ();

    colors_to_bytes #(
        .FIFO_DEPTH (DEPTH),
        .PAD_NIBBLE (PAD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        inclk;
        logic [11:0] color;
        logic        inDone;
        logic        drdy;
        logic        expOutclk;
        logic [7:0]  expOut;
        logic        expDone;
        logic        expRdy;
    } vec_t;

    vec_t       vecs [NV];
    logic [7:0] gotQ [$];
    logic [7:0] expQ [$];
    logic [3:0] nibQ [$];
    int         doneCount = 0;
    longint     doneTime  = 0;
    longint     tIn;
    longint     kDone;
    logic [11:0] randColor;
    logic        randGo;
    int          waitCount;

    // Byte and done monitor, sampled half a cycle after the registered outputs move.
    always @(negedge clk) begin
        if (bus.outclk) gotQ.push_back(bus.out);
        if (bus.done) begin
            doneCount++;
            doneTime = $time;
        end
    end

    task automatic applyStimulus(input logic ic, input logic [11:0] c, input logic id, input logic dr);
        @(negedge clk);
        bus.inclk          = ic;
        bus.in             = c;
        bus.in_done        = id;
        bus.downstream_rdy = dr;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic compareBytes(input string name);
        checkOutput({name, " byte count"}, 32'(gotQ.size()), 32'(expQ.size()));
        for (int i = 0; i < expQ.size() && i < gotQ.size(); i++) begin
            checkOutput($sformatf("%s byte%0d", name, i), 32'(gotQ[i]), 32'(expQ[i]));
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        rst                = 1'b1;
        bus.inclk          = 1'b0;
        bus.in_done        = 1'b0;
        bus.downstream_rdy = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0]  = '{1'b1, 12'hABC, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1};
        vecs[1]  = '{1'b1, 12'hDEF, 1'b0, 1'b1, 1'b1, 8'hAB, 1'b0, 1'b1};
        vecs[2]  = '{1'b0, 12'h000, 1'b0, 1'b1, 1'b1, 8'hCD, 1'b0, 1'b1};
        vecs[3]  = '{1'b0, 12'h000, 1'b0, 1'b1, 1'b1, 8'hEF, 1'b0, 1'b1};
        vecs[4]  = '{1'b0, 12'h000, 1'b0, 1'b1, 1'b0, 8'hEF, 1'b0, 1'b1};
        vecs[5]  = '{1'b1, 12'hABC, 1'b0, 1'b1, 1'b0, 8'hEF, 1'b0, 1'b1};
        vecs[6]  = '{1'b0, 12'h000, 1'b1, 1'b1, 1'b1, 8'hAB, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 12'h000, 1'b0, 1'b1, 1'b0, 8'hAB, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 12'h000, 1'b0, 1'b1, 1'b1, 8'hC0, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 12'h000, 1'b0, 1'b1, 1'b0, 8'hC0, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 12'h000, 1'b0, 1'b1, 1'b0, 8'hC0, 1'b0, 1'b1};
        vecs[11] = '{1'b1, 12'h123, 1'b0, 1'b1, 1'b0, 8'hC0, 1'b0, 1'b1};
        vecs[12] = '{1'b1, 12'h456, 1'b1, 1'b1, 1'b1, 8'h12, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 12'h000, 1'b0, 1'b1, 1'b1, 8'h34, 1'b0, 1'b0};
        vecs[14] = '{1'b0, 12'h000, 1'b0, 1'b1, 1'b1, 8'h56, 1'b0, 1'b0};
        vecs[15] = '{1'b0, 12'h000, 1'b0, 1'b1, 1'b0, 8'h56, 1'b1, 1'b0};
        vecs[16] = '{1'b0, 12'h000, 1'b0, 1'b1, 1'b0, 8'h56, 1'b0, 1'b1};

        rst                = 1'b1;
        bus.inclk          = 1'b0;
        bus.in             = '0;
        bus.in_done        = 1'b0;
        bus.downstream_rdy = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset outclk", 32'(bus.outclk), 32'd0);
        checkOutput("reset out", 32'(bus.out), 32'd0);
        checkOutput("reset done", 32'(bus.done), 32'd0);
        checkOutput("reset overflow", 32'(bus.overflow), 32'd0);
        checkOutput("reset rdy", 32'(bus.rdy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("post-reset rdy", 32'(bus.rdy), 32'd1);

        // Cycle-exact table: pair packing, odd flush with pad, in_done alongside a color.
        for (int i = 0; i < NV; i++) begin
            applyStimulus(vecs[i].inclk, vecs[i].color, vecs[i].inDone, vecs[i].drdy);
            checkOutput($sformatf("vec%0d outclk", i), 32'(bus.outclk), 32'(vecs[i].expOutclk));
            checkOutput($sformatf("vec%0d out", i), 32'(bus.out), 32'(vecs[i].expOut));
            checkOutput($sformatf("vec%0d done", i), 32'(bus.done), 32'(vecs[i].expDone));
            checkOutput($sformatf("vec%0d rdy", i), 32'(bus.rdy), 32'(vecs[i].expRdy));
        end
        checkOutput("table overflow", 32'(bus.overflow), 32'd0);

        // Backpressure fills the FIFO; a color offered while not ready is dropped.
        gotQ.delete();
        applyStimulus(1'b1, 12'h111, 1'b0, 1'b0);
        checkOutput("bp rdy after 1 color", 32'(bus.rdy), 32'd1);
        applyStimulus(1'b1, 12'h222, 1'b0, 1'b0);
        checkOutput("bp rdy low", 32'(bus.rdy), 32'd0);
        applyStimulus(1'b1, 12'h333, 1'b0, 1'b0);
        checkOutput("overflow set", 32'(bus.overflow), 32'd1);
        repeat (6) applyStimulus(1'b0, 12'h000, 1'b0, 1'b1);
        expQ = '{8'h11, 8'h12, 8'h22};
        compareBytes("backpressure");
        checkOutput("overflow sticky", 32'(bus.overflow), 32'd1);
        checkOutput("rdy after drain", 32'(bus.rdy), 32'd1);

        // Reset mid-stream discards the queued byte and clears overflow.
        doReset();
        #1;
        checkOutput("overflow cleared", 32'(bus.overflow), 32'd0);
        applyStimulus(1'b1, 12'hABC, 1'b0, 1'b0);
        gotQ.delete();
        @(negedge clk);
        rst                = 1'b1;
        bus.inclk          = 1'b0;
        bus.downstream_rdy = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("midreset outclk", 32'(bus.outclk), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) applyStimulus(1'b0, 12'h000, 1'b0, 1'b1);
        checkOutput("midreset no bytes", 32'(gotQ.size()), 32'd0);
        applyStimulus(1'b1, 12'h0F0, 1'b0, 1'b1);
        applyStimulus(1'b1, 12'h0F0, 1'b0, 1'b1);
        repeat (5) applyStimulus(1'b0, 12'h000, 1'b0, 1'b1);
        expQ = '{8'h0F, 8'h00, 8'hF0};
        compareBytes("after reset");

        // in_done with nothing buffered: done lands 2..3 cycles later, no pad byte.
        gotQ.delete();
        doneCount = 0;
        applyStimulus(1'b0, 12'h000, 1'b1, 1'b1);
        tIn = longint'($time) - 1;
        repeat (6) applyStimulus(1'b0, 12'h000, 1'b0, 1'b1);
        checkOutput("empty done count", 32'(doneCount), 32'd1);
        kDone = (doneTime - tIn + 5) / 10;
        checkOutput("empty done window", 32'((kDone >= 2) && (kDone <= 3)), 32'd1);
        checkOutput("empty no bytes", 32'(gotQ.size()), 32'd0);

        // Random streams: model is the concatenated nibble stream cut into bytes.
        for (int s = 0; s < 3; s++) begin
            nibQ.delete();
            expQ.delete();
            gotQ.delete();
            doneCount = 0;
            for (int c = 0; c < 40; c++) begin
                @(negedge clk);
                randColor          = 12'($urandom);
                randGo             = bus.rdy && ($urandom_range(0, 2) != 0);
                bus.inclk          = randGo;
                bus.in             = randColor;
                bus.in_done        = 1'b0;
                bus.downstream_rdy = ($urandom_range(0, 3) != 0);
                if (randGo) begin
                    nibQ.push_back(randColor[11:8]);
                    nibQ.push_back(randColor[7:4]);
                    nibQ.push_back(randColor[3:0]);
                end
                @(posedge clk);
                #1;
            end
            applyStimulus(1'b0, 12'h000, 1'b1, 1'b1);
            if (nibQ.size() % 2 != 0) nibQ.push_back(PAD);
            for (int i = 0; i + 1 < nibQ.size(); i += 2) begin
                expQ.push_back({nibQ[i], nibQ[i + 1]});
            end
            waitCount = 0;
            while (doneCount == 0 && waitCount < 200) begin
                applyStimulus(1'b0, 12'h000, 1'b0, 1'($urandom_range(0, 1)));
                waitCount++;
            end
            checkOutput($sformatf("rand%0d done seen", s), 32'(doneCount), 32'd1);
            compareBytes($sformatf("rand%0d", s));
            checkOutput($sformatf("rand%0d overflow", s), 32'(bus.overflow), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
